// File: rtl/periph_pkg.sv
// Shared constants for the memory-mapped peripheral block: register offsets,
// TCON bit positions and the default 7-segment scan period.
package periph_pkg;

  localparam logic [15:0] SCAN_DIV_DEFAULT = 16'd50000;

  localparam logic [7:0] OFF_TH      = 8'h00;
  localparam logic [7:0] OFF_TL      = 8'h04;
  localparam logic [7:0] OFF_TCON    = 8'h08;
  localparam logic [7:0] OFF_LED     = 8'h0C;
  localparam logic [7:0] OFF_DIGITS  = 8'h10;
  localparam logic [7:0] OFF_SYSTICK = 8'h14;

  // Word-select values seen on Address[4:2].
  localparam logic [2:0] SEL_TH      = OFF_TH[4:2];
  localparam logic [2:0] SEL_TL      = OFF_TL[4:2];
  localparam logic [2:0] SEL_TCON    = OFF_TCON[4:2];
  localparam logic [2:0] SEL_LED     = OFF_LED[4:2];
  localparam logic [2:0] SEL_DIGITS  = OFF_DIGITS[4:2];
  localparam logic [2:0] SEL_SYSTICK = OFF_SYSTICK[4:2];

  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_IS = 2;

endpackage

// File: rtl/periph_bus_if.sv
// CPU MEM-stage bus into the peripheral window.
// MemRead/MemWrite are single-cycle strobes with no ready: a read returns data
// combinationally in the same cycle, a write commits on that cycle's clk edge.
interface periph_bus_if;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;

  modport master (output MemRead, output MemWrite, output Address,
                  output WriteData, input ReadData);
  modport slave  (input MemRead, input MemWrite, input Address,
                  input WriteData, output ReadData);
endinterface

// File: rtl/seg7_decoder.sv
// Hex nibble to active-low 7-segment glyph {dp,g,f,e,d,c,b,a}; dp always off.
module seg7_decoder (
  input  logic [3:0] hexVal,
  output logic [7:0] segN
);
  always_comb begin
    segN = 8'hFF;
    case (hexVal)
      4'h0: segN = 8'hC0;
      4'h1: segN = 8'hF9;
      4'h2: segN = 8'hA4;
      4'h3: segN = 8'hB0;
      4'h4: segN = 8'h99;
      4'h5: segN = 8'h92;
      4'h6: segN = 8'h82;
      4'h7: segN = 8'hF8;
      4'h8: segN = 8'h80;
      4'h9: segN = 8'h90;
      4'hA: segN = 8'h88;
      4'hB: segN = 8'h83;
      4'hC: segN = 8'hC6;
      4'hD: segN = 8'hA1;
      4'hE: segN = 8'h86;
      4'hF: segN = 8'h8E;
      default: segN = 8'hFF;
    endcase
  end
endmodule

// File: rtl/periph_bus.sv
// Memory-mapped peripheral block: reload timer with interrupt, free-running
// SYSTICK, LED register and a multiplexed four-digit 7-segment display.
module periph_bus
  import periph_pkg::*;
#(
  parameter logic [31:0] BASE     = 32'h4000_0000,
  parameter logic [15:0] SCAN_DIV = SCAN_DIV_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  periph_bus_if.slave  bus,
  output logic [7:0]   leds,
  output logic [7:0]   bcd7,
  output logic [3:0]   an,
  output logic         irq
);

  logic [31:0] th, tl, sysTick;
  logic [2:0]  tcon;
  logic [7:0]  ledReg;
  logic [15:0] digits;
  logic [15:0] scanCnt;
  logic [1:0]  digitIdx;
  logic [3:0]  curNibble;

  logic       hit;
  logic [2:0] regSel;
  logic       wrTh, wrTl, wrTcon, wrLed, wrDigits;

  assign hit    = (bus.Address[31:5] == BASE[31:5]);
  assign regSel = bus.Address[4:2];

  assign wrTh     = bus.MemWrite && hit && (regSel == SEL_TH);
  assign wrTl     = bus.MemWrite && hit && (regSel == SEL_TL);
  assign wrTcon   = bus.MemWrite && hit && (regSel == SEL_TCON);
  assign wrLed    = bus.MemWrite && hit && (regSel == SEL_LED);
  assign wrDigits = bus.MemWrite && hit && (regSel == SEL_DIGITS);

  // Hardware timer update first; CPU writes below override it in the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th      <= 32'h0;
      tl      <= 32'h0;
      tcon    <= 3'b000;
      ledReg  <= 8'h00;
      digits  <= 16'h0000;
      sysTick <= 32'h0;
    end else begin
      sysTick <= sysTick + 32'd1;
      if (tcon[TCON_EN]) begin
        if (tl == 32'hFFFF_FFFF) begin
          tl <= th;
          if (tcon[TCON_IE]) tcon[TCON_IS] <= 1'b1;
        end else begin
          tl <= tl + 32'd1;
        end
      end
      if (wrTh)     th     <= bus.WriteData;
      if (wrTl)     tl     <= bus.WriteData;
      if (wrTcon)   tcon   <= bus.WriteData[2:0];
      if (wrLed)    ledReg <= bus.WriteData[7:0];
      if (wrDigits) digits <= bus.WriteData[15:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scanCnt  <= 16'd0;
      digitIdx <= 2'd0;
    end else if (scanCnt == SCAN_DIV - 16'd1) begin
      scanCnt  <= 16'd0;
      digitIdx <= digitIdx + 2'd1;
    end else begin
      scanCnt  <= scanCnt + 16'd1;
    end
  end

  always_comb begin
    bus.ReadData = 32'h0;
    if (bus.MemRead && hit) begin
      case (regSel)
        SEL_TH:      bus.ReadData = th;
        SEL_TL:      bus.ReadData = tl;
        SEL_TCON:    bus.ReadData = {29'h0, tcon};
        SEL_LED:     bus.ReadData = {24'h0, ledReg};
        SEL_DIGITS:  bus.ReadData = {16'h0, digits};
        SEL_SYSTICK: bus.ReadData = sysTick;
        default:     bus.ReadData = 32'h0;
      endcase
    end
  end

  // an and the glyph both derive from digitIdx alone, so they switch together.
  always_comb begin
    an        = 4'b1110;
    curNibble = digits[3:0];
    case (digitIdx)
      2'd0: begin an = 4'b1110; curNibble = digits[3:0];   end
      2'd1: begin an = 4'b1101; curNibble = digits[7:4];   end
      2'd2: begin an = 4'b1011; curNibble = digits[11:8];  end
      2'd3: begin an = 4'b0111; curNibble = digits[15:12]; end
      default: begin an = 4'b1110; curNibble = digits[3:0]; end
    endcase
  end

  seg7_decoder u_seg7 (
    .hexVal (curNibble),
    .segN   (bcd7)
  );

  assign leds = ledReg;
  assign irq  = tcon[TCON_IE] & tcon[TCON_IS];

endmodule

// File: tb/tb_periph_bus.sv
// Directed-vector bench for periph_bus with a 4-cycle digit scan period.
module tb_periph_bus;
  import periph_pkg::*;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic [31:0] A_TH      = BASE + 32'h00;
  localparam logic [31:0] A_TL      = BASE + 32'h04;
  localparam logic [31:0] A_TCON    = BASE + 32'h08;
  localparam logic [31:0] A_LED     = BASE + 32'h0C;
  localparam logic [31:0] A_DIGITS  = BASE + 32'h10;
  localparam logic [31:0] A_SYSTICK = BASE + 32'h14;

  logic        clk;
  logic        reset;
  logic [7:0]  leds;
  logic [7:0]  bcd7;
  logic [3:0]  an;
  logic        irq;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [11:0] exp_q[$];

  periph_bus_if bus ();

  periph_bus #(.BASE(BASE), .SCAN_DIV(16'd4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .leds  (leds),
    .bcd7  (bcd7),
    .an    (an),
    .irq   (irq)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // driver tasks; each is entered and left at posedge+1
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    bus.Address   = addr;
    bus.WriteData = data;
    bus.MemWrite  = 1'b1;
    @(posedge clk);
    #1;
    bus.MemWrite  = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    bus.Address = addr;
    bus.MemRead = 1'b1;
    #1;
    data = bus.ReadData;
    bus.MemRead = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic [3:0]  an_tab [4];
    logic [7:0]  seg_tab[4];
    logic [11:0] exp;
    int idx;

    an_tab  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    seg_tab = '{8'h8E, 8'hB0, 8'h88, 8'hF9};

    reset         = 1'b1;
    bus.MemRead   = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.Address   = 32'h0;
    bus.WriteData = 32'h0;

    // reset state
    tick(2);
    check_val("rst_leds", {24'h0, leds}, 32'h00);
    check_val("rst_an",   {28'h0, an},   32'hE);
    check_val("rst_bcd7", {24'h0, bcd7}, 32'hC0);
    check_val("rst_irq",  {31'h0, irq},  32'h0);
    bus_read(A_SYSTICK, rd);
    check_val("rst_systick", rd, 32'h0);

    // SYSTICK after 10 cycles, unmapped and idle reads
    reset = 1'b0;
    tick(10);
    bus_read(A_SYSTICK, rd);
    check_val("systick_10", rd, 32'd10);
    bus_read(BASE + 32'h18, rd);
    check_val("unmapped_18", rd, 32'h0);
    bus_read(BASE + 32'h34, rd);
    check_val("outside_window", rd, 32'h0);
    bus.Address = A_SYSTICK;
    #1;
    check_val("read_idle", bus.ReadData, 32'h0);
    bus_read(A_SYSTICK + 32'h3, rd);
    check_val("systick_lowbits", rd, 32'd10);

    // digit scan: edge n after reset shows digit (n/4)%4
    tick(1);
    do_reset();
    bus_write(A_DIGITS, 32'h0000_1A3F);
    bus_read(A_DIGITS, rd);
    check_val("digits_rd", rd, 32'h1A3F);
    for (int n = 1; n <= 16; n++) begin
      idx = (n / 4) % 4;
      exp_q.push_back({an_tab[idx], seg_tab[idx]});
    end
    for (int n = 1; n <= 16; n++) begin
      exp = exp_q.pop_front();
      check_val("scan_an",  {28'h0, an},   {28'h0, exp[11:8]});
      check_val("scan_seg", {24'h0, bcd7}, {24'h0, exp[7:0]});
      tick(1);
    end

    // timer reload with interrupt
    bus_write(A_TH, 32'hFFFF_FFF0);
    bus_write(A_TL, 32'hFFFF_FFFE);
    bus_write(A_TCON, 32'h3);
    bus_read(A_TL, rd);
    check_val("tl_start", rd, 32'hFFFF_FFFE);
    tick(1);
    bus_read(A_TL, rd);
    check_val("tl_max", rd, 32'hFFFF_FFFF);
    check_val("irq_before", {31'h0, irq}, 32'h0);
    tick(1);
    bus_read(A_TL, rd);
    check_val("tl_reload", rd, 32'hFFFF_FFF0);
    bus_read(A_TCON, rd);
    check_val("tcon_status", rd, 32'h7);
    check_val("irq_set", {31'h0, irq}, 32'h1);
    bus_write(A_TCON, 32'h3);
    check_val("irq_clear", {31'h0, irq}, 32'h0);
    bus_read(A_TCON, rd);
    check_val("tcon_clear", rd, 32'h3);

    // reload with interrupt disabled
    bus_write(A_TCON, 32'h0);
    bus_write(A_TL, 32'hFFFF_FFFF);
    bus_read(A_TL, rd);
    check_val("tl_hold", rd, 32'hFFFF_FFFF);
    bus_write(A_TCON, 32'h1);
    tick(1);
    bus_read(A_TL, rd);
    check_val("tl_reload_noie", rd, 32'hFFFF_FFF0);
    bus_read(A_TCON, rd);
    check_val("tcon_noie", rd, 32'h1);
    check_val("irq_noie", {31'h0, irq}, 32'h0);

    // CPU write beats the hardware increment
    bus_write(A_TL, 32'd5);
    bus_read(A_TL, rd);
    check_val("tl_cpu_wins", rd, 32'd5);
    tick(1);
    bus_read(A_TL, rd);
    check_val("tl_after", rd, 32'd6);

    // LED, then asynchronous reset mid-count with irq pending
    bus_write(A_LED, 32'hA5);
    check_val("leds", {24'h0, leds}, 32'hA5);
    bus_write(A_TCON, 32'h3);
    bus_write(A_TL, 32'hFFFF_FFFF);
    tick(1);
    check_val("irq_pre_reset", {31'h0, irq}, 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check_val("async_leds", {24'h0, leds}, 32'h00);
    check_val("async_an",   {28'h0, an},   32'hE);
    check_val("async_bcd7", {24'h0, bcd7}, 32'hC0);
    check_val("async_irq",  {31'h0, irq},  32'h0);
    bus_read(A_TL, rd);
    check_val("async_tl", rd, 32'h0);
    bus_read(A_SYSTICK, rd);
    check_val("async_systick", rd, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick(1);
    bus_read(A_SYSTICK, rd);
    check_val("post_reset_tick", rd, 32'd1);
    bus_read(A_TCON, rd);
    check_val("post_reset_tcon", rd, 32'h0);
    check_val("post_reset_irq", {31'h0, irq}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/periph_bus.md
PERIPH_BUS -- requirements
Module: periph_bus

Interface
REQ-001 The block SHALL have parameter BASE, default 32'h4000_0000, meaning the peripheral window base address.
REQ-002 The block SHALL have parameter SCAN_DIV, default 16'd50000, meaning clk cycles per 7-segment digit slot.
REQ-003 The block SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port MemRead  input  1  CPU MEM-stage read strobe.
REQ-006 The block SHALL have port MemWrite  input  1  CPU MEM-stage write strobe.
REQ-007 The block SHALL have port Address  input  32  CPU byte address (ALU result).
REQ-008 The block SHALL have port WriteData  input  32  CPU store data.
REQ-009 The block SHALL have port ReadData  output  32  register read data.
REQ-010 The block SHALL have port leds  output  8  LED register value.
REQ-011 The block SHALL have port bcd7  output  8  active-low segments {dp,g..a}.
REQ-012 The block SHALL have port an  output  4  active-low digit enables.
REQ-013 The block SHALL have port irq  output  1  timer interrupt request.

Function
REQ-014 The register map SHALL be: BASE+0x00 TH (rw); +0x04 TL (rw); +0x08 TCON[2:0] (rw; bit0 enable, bit1 irq enable, bit2 irq status); +0x0C LED[7:0] (rw); +0x10 DIGITS[15:0] (rw, four hex nibbles, nibble 0 = rightmost); +0x14 SYSTICK (read-only).
REQ-015 Decode SHALL use Address[31:5] == BASE[31:5] and Address[4:2]; Address[1:0] is ignored.
REQ-016 Reads SHALL be combinational: ReadData is valid in the same cycle MemRead is asserted, with unused upper bits zero.
REQ-017 When MemRead is low or the address is unmapped, ReadData SHALL be 32'h0.
REQ-018 Writes SHALL commit on the clk edge on which MemWrite is high; writes to unmapped addresses or to SYSTICK are ignored.
REQ-019 SYSTICK SHALL increment by 1 every cycle and wrap modulo 2^32.
REQ-020 When TCON[0]=1, TL SHALL increment by 1 per cycle.
REQ-021 When TL == 32'hFFFF_FFFF and TCON[0]=1, TL SHALL load TH on the next edge instead of wrapping, and TCON[2] SHALL be set if TCON[1]=1.
REQ-022 A CPU write to TL or TCON in the same cycle as a hardware update SHALL take priority over the hardware update.
REQ-023 TCON[2] SHALL clear only by CPU write.
REQ-024 irq SHALL equal TCON[1] & TCON[2], registered-state derived with no combinational path from the inputs.
REQ-025 A scan divider SHALL count 0..SCAN_DIV-1; on wrap, a 2-bit digit index advances 0->1->2->3->0.
REQ-026 an SHALL be the active-low one-hot of the digit index (index 0 -> 4'b1110).
REQ-027 bcd7 SHALL be the active-low hex glyph of the indexed DIGITS nibble, with dp off (bit7=1).
REQ-028 bcd7 and an SHALL change in the same cycle.
REQ-029 leds SHALL equal LED[7:0] directly.

Reset
REQ-030 While reset is high, TH, TL, TCON, LED, DIGITS, SYSTICK, the scan divider and the digit index SHALL be 0 asynchronously.
REQ-031 Consequently, under reset leds=8'h00, an=4'b1110, bcd7=glyph "0" (8'hC0), and irq=0.
REQ-032 Reset asserted mid-count SHALL abort the timer with no irq, and the first post-reset cycle SHALL behave as cycle 0.

Structure
REQ-033 Register offsets, TCON bit positions and the SCAN_DIV default SHALL live in shared package periph_pkg.
REQ-034 The hex-to-7-segment glyph table SHALL be a combinational sub-module named seg7_decoder, reusable by other display logic.

Verification
REQ-035 The bench SHALL cover: reset, then read SYSTICK at cycle 10 -> 32'd10; read unmapped BASE+0x18 -> 0.
REQ-036 The bench SHALL cover: write TH=32'hFFFF_FFF0, TL=32'hFFFF_FFFE, TCON=3'b011 -> TL reaches FFFF_FFFF next cycle, then loads FFFF_FFF0, TCON reads 3'b111 and irq=1; write TCON=3'b011 -> irq=0.
REQ-037 The bench SHALL cover: write TCON=3'b001 with TL at FFFF_FFFF -> reload occurs, TCON[2] stays 0, irq=0.
REQ-038 The bench SHALL cover: write TL=5 in the same cycle as a timer increment -> TL reads 5, then 6.
REQ-039 The bench SHALL cover: with SCAN_DIV=4, write DIGITS=16'h1A3F -> an/bcd7 sequence 1110/8E, 1101/B0, 1011/88, 0111/F9, with each held 4 cycles.
REQ-040 The bench SHALL cover: write LED=8'hA5 -> leds=8'hA5; assert reset mid-count -> all outputs return to reset values immediately, without waiting for a clk edge.
